// File: rtl/lcd_spi_fifo.sv
// lcd_spi_fifo: buffered 4-wire SPI transmitter for an ILI9341V LCD.
//
// The CPU pushes byte, 16-bit word and chip-select-release entries into a
// circular transmit FIFO. An IDLE/LO/HI engine drains the FIFO onto SPI
// mode 0, MSB first. Each SCK half-period lasts CLKDIV clk cycles.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, 2..128)
//   CLKDIV  clk cycles per SCK half-period (1..255)
// Ports:
//   clk     system clock
//   reset   asynchronous, active-high reset
//   load    push a byte entry (in[8]=0) or a CSX-release entry (in[8]=1);
//           in[9] is the DCX value the entry carries
//   load16  push a 16-bit data word (DCX=1); ignored while load is high
//   in      entry payload
//   out     status {busy, full, overflow, 5'b0, level[7:0]}
//   DCX     data/command-not
//   CSX     chip select, active low
//   SDO     serial data, stable across every SCK rise
//   SCK     serial clock, idles low
//
// Push handshake: load/load16 is a single-cycle push with no back-pressure.
// The push is accepted when the FIFO is not full at that clock edge, even if
// a pop happens on the same edge. A push into a full FIFO is dropped and sets
// the sticky overflow flag, which only reset clears.
module lcd_spi_fifo #(
  parameter int DEPTH  = 16,
  parameter int CLKDIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load16,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        DCX,
  output logic        CSX,
  output logic        SDO,
  output logic        SCK
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 19;  // {csx_rel, w16, dcx, data[15:0]}

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]  DIV_LAST   = 8'(CLKDIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  // FIFO storage and bookkeeping
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;

  // Serial engine
  logic [1:0]    state_q, state_d;
  logic [15:0]   sh_q, sh_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    div_q, div_d;
  logic          csx_q, csx_d;
  logic          dcx_q, dcx_d;
  logic          sck_q, sck_d;

  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          busy;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;
  logic [7:0]    level8;

  // Entry construction; load has priority over load16.
  always_comb begin
    push_req = load | load16;
    if (load) begin
      if (in[8]) begin
        push_entry = {1'b1, 1'b0, in[9], 16'h0000};
      end else begin
        push_entry = {1'b0, 1'b0, in[9], 8'h00, in[7:0]};
      end
    end else begin
      push_entry = {1'b0, 1'b1, 1'b1, in};
    end
  end

  assign full    = (level_q == LEVEL_FULL);
  assign push_ok = push_req & ~full;
  assign head    = mem_q[rd_ptr_q];
  // Pops only look at the registered level, so a push into an empty FIFO is
  // popped on the following edge at the earliest.
  assign pop     = (state_q == ST_IDLE) && (level_q != '0);
  assign busy    = (level_q != '0) || (state_q != ST_IDLE);

  always_comb begin
    level8         = '0;
    level8[AW:0]   = level_q;
  end

  assign out = {busy, full, ovf_q, 5'b00000, level8};

  // FIFO pointer/level update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q | (push_req & full);
  end

  // Storage needs no reset: the pointers and level define which slots are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Serial engine. Bytes are left-aligned in the shift register so the
  // outgoing bit is always sh_q[15] for both byte and word transfers.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    div_d    = div_q;
    csx_d    = csx_q;
    dcx_d    = dcx_q;
    sck_d    = sck_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          dcx_d = head[16];
          if (head[18]) begin
            csx_d = 1'b1;
          end else begin
            csx_d    = 1'b0;
            sh_d     = head[17] ? head[15:0] : {head[7:0], 8'h00};
            bitcnt_d = head[17] ? 4'd15 : 4'd7;
            div_d    = 8'd0;
            state_d  = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (div_q == DIV_LAST) begin
          sck_d   = 1'b1;
          div_d   = 8'd0;
          state_d = ST_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HI: begin
        if (div_q == DIV_LAST) begin
          // Falling edge: the next bit moves onto SDO together with SCK low.
          sck_d = 1'b0;
          sh_d  = {sh_q[14:0], 1'b0};
          div_d = 8'd0;
          if (bitcnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            bitcnt_d = bitcnt_q - 4'd1;
            state_d  = ST_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      sh_q     <= 16'h0000;
      bitcnt_q <= 4'd0;
      div_q    <= 8'd0;
      csx_q    <= 1'b1;
      dcx_q    <= 1'b0;
      sck_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      csx_q    <= csx_d;
      dcx_q    <= dcx_d;
      sck_q    <= sck_d;
    end
  end

  assign CSX = csx_q;
  assign DCX = dcx_q;
  assign SCK = sck_q;
  assign SDO = sh_q[15];

endmodule
